m_ext_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, directly downstream of the control unit.
- Used when the control unit flags an M-extension instruction (funct_7 = 7'b0000001, opcode 7'b0110011).
- Takes funct_3 plus both register operands, computes over multiple cycles, and returns a 32-bit result.
- The writeback mux selects this result in place of the ALU result.

---
 rtl/m_ext_unit.sv | 186 ++++++++++++++++++
 tb/tb_m_ext_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional M_EXT_EARLY_OUT_EN lets trivial cases (div by zero, overflow, multiply by 0) skip CALC.
module m_ext_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            ip_clk,
    input  logic            ip_rst_n,
    input  logic            ip_start,
    input  logic            ip_kill,
    input  logic [2:0]      ip_funct_3,
    input  logic [XLEN-1:0] ip_operand_a,
    input  logic [XLEN-1:0] ip_operand_b,
    output logic [XLEN-1:0] op_result,
    output logic            op_busy,
    output logic            op_done
);

    localparam int unsigned CntW = $clog2(ITER + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ITER);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        funct_q, funct_d;
    logic              neg_q, neg_d;
    logic              div0_q, div0_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg, cap_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_res;

    // Operand preparation: magnitudes plus the sign the result must carry.
    always_comb begin
        a_signed = (ip_funct_3 == 3'd1) || (ip_funct_3 == 3'd2) ||
                   (ip_funct_3 == 3'd4) || (ip_funct_3 == 3'd6);
        b_signed = (ip_funct_3 == 3'd1) || (ip_funct_3 == 3'd4) || (ip_funct_3 == 3'd6);
        a_neg    = a_signed && ip_operand_a[XLEN-1];
        b_neg    = b_signed && ip_operand_b[XLEN-1];
        a_mag    = a_neg ? -ip_operand_a : ip_operand_a;
        b_mag    = b_neg ? -ip_operand_b : ip_operand_b;
        // Remainder follows the dividend; everything else follows the operand signs.
        cap_neg  = (ip_funct_3[2] && ip_funct_3[1]) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef M_EXT_EARLY_OUT_EN
    logic            eo_div0, eo_ovf, eo_mulz, eo_hit;
    logic [XLEN-1:0] eo_val;

    always_comb begin
        eo_div0 = ip_funct_3[2] && (ip_operand_b == '0);
        eo_ovf  = ((ip_funct_3 == 3'd4) || (ip_funct_3 == 3'd6)) &&
                  (ip_operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (ip_operand_b == '1);
        eo_mulz = !ip_funct_3[2] && ((ip_operand_a == '0) || (ip_operand_b == '0));
        eo_hit  = eo_div0 || eo_ovf || eo_mulz;
        eo_val  = '0;
        if (eo_div0) begin
            eo_val = ip_funct_3[1] ? ip_operand_a : '1;
        end else if (eo_ovf) begin
            eo_val = ip_funct_3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    // One iteration of each datapath; only the one matching funct_q matters.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        if (!div_diff[XLEN+1]) begin
            rem_next  = div_diff[XLEN:0];
            quot_next = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = div_shift;
            quot_next = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix  = neg_q ? -prod_q : prod_q;
        final_res = '0;
        unique case (funct_q)
            3'd0:                   final_res = prod_q[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (div0_q) final_res = '1;
                else        final_res = neg_q ? -quot_q : quot_q;
            end
            default:                final_res = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct_d  = funct_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        opb_d    = opb_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (ip_start && !ip_kill) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    funct_d = ip_funct_3;
                    neg_d   = cap_neg;
                    div0_d  = (ip_operand_b == '0);
                    prod_d  = {{XLEN{1'b0}}, a_mag};
                    rem_d   = '0;
                    quot_d  = a_mag;
                    opb_d   = b_mag;
`ifdef M_EXT_EARLY_OUT_EN
                    if (eo_hit) begin
                        state_d  = StDone;
                        result_d = eo_val;
                    end
`endif
                end
            end
            StCalc: begin
                if (ip_kill) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d  = StDone;
                    result_d = final_res;
                end else begin
                    cnt_d  = cnt_q + CntW'(1);
                    prod_d = mul_next;
                    rem_d  = rem_next;
                    quot_d = quot_next;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct_q  <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct_q  <= funct_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign op_result = result_q;
    assign op_busy   = (state_q == StCalc);
    assign op_done   = (state_q == StDone);

endmodule

// File: tb/tb_m_ext_unit.sv
// Randomized bench for m_ext_unit against an arithmetic RV32M reference model.
// Honours M_EXT_EARLY_OUT_EN when computing expected latency.
module tb_m_ext_unit;

    logic        ip_clk_tb = 1'b0;
    logic        ip_rst_n_tb;
    logic        start_tb;
    logic        kill_tb;
    logic [2:0]  funct_tb;
    logic [31:0] a_tb;
    logic [31:0] b_tb;
    logic [31:0] result_tb;
    logic        busy_tb;
    logic        done_tb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ip_clk_tb = ~ip_clk_tb;

    m_ext_unit #(
        .XLEN(32),
        .ITER(32)
    ) u_dut (
        .ip_clk      (ip_clk_tb),
        .ip_rst_n    (ip_rst_n_tb),
        .ip_start    (start_tb),
        .ip_kill     (kill_tb),
        .ip_funct_3  (funct_tb),
        .ip_operand_a(a_tb),
        .ip_operand_b(b_tb),
        .op_result   (result_tb),
        .op_busy     (busy_tb),
        .op_done     (done_tb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      ux;
        longint      uy;
        longint      q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                q = sx / sy;
                return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                q = sx % sy;
                return q[31:0];
            end
            default: begin
                if (y == 0) return x;
                q = ux % uy;
                return q[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x,
                                       input logic [31:0] y);
`ifdef M_EXT_EARLY_OUT_EN
        if ((f[2] && y == 0) ||
            ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ||
            (!f[2] && (x == 0 || y == 0)))
            return 0;
`endif
        return 33;
    endfunction

    // Issue one operation; optionally poke ip_start with junk operands mid-run.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input int poke_at, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          k;
        logic        busy_ok;
        exp     = ref_model(f, x, y);
        exp_lat = ref_latency(f, x, y);
        @(negedge ip_clk_tb);
        start_tb = 1'b1;
        funct_tb = f;
        a_tb     = x;
        b_tb     = y;
        @(posedge ip_clk_tb);
        #1;
        start_tb = 1'b0;
        k        = 0;
        busy_ok  = 1'b1;
        while (!done_tb && k < 100) begin
            if (!busy_tb) busy_ok = 1'b0;
            if (k == poke_at) begin
                start_tb = 1'b1;
                funct_tb = 3'd0;
                a_tb     = $urandom;
                b_tb     = $urandom;
            end else begin
                start_tb = 1'b0;
            end
            @(posedge ip_clk_tb);
            #1;
            k++;
        end
        start_tb = 1'b0;
        check($sformatf("%s f%0d %h %h result", tag, f, x, y), result_tb, exp);
        check($sformatf("%s f%0d latency", tag, f), 32'(k), 32'(exp_lat));
        check($sformatf("%s busy in calc", tag), {31'b0, busy_ok}, 32'd1);
        check($sformatf("%s busy in done", tag), {31'b0, busy_tb}, 32'd0);
        @(posedge ip_clk_tb);
        #1;
        check($sformatf("%s done pulse width", tag), {31'b0, done_tb}, 32'd0);
        check($sformatf("%s result held", tag), result_tb, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int          k;
        logic        saw_done;

        ip_rst_n_tb = 1'b0;
        start_tb    = 1'b0;
        kill_tb     = 1'b0;
        funct_tb    = 3'd0;
        a_tb        = '0;
        b_tb        = '0;
        repeat (3) @(posedge ip_clk_tb);
        #1;
        check("reset result", result_tb, 32'h0);
        check("reset busy", {31'b0, busy_tb}, 32'd0);
        check("reset done", {31'b0, done_tb}, 32'd0);
        @(negedge ip_clk_tb);
        ip_rst_n_tb = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1, "rem");
        run_op(3'd5, 32'd100, 32'd7, -1, "divu");
        run_op(3'd7, 32'd100, 32'd7, -1, "remu");
        run_op(3'd5, 32'd5, 32'd0, -1, "divu0");
        run_op(3'd7, 32'd5, 32'd0, -1, "remu0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, -1, "div0neg");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, "divovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, "removf");
        run_op(3'd0, 32'd0, 32'h1234_5678, -1, "mulz");
        run_op(3'd4, 32'd9, 32'd3, 10, "ignored start");

        // Kill mid-calculation: no done pulse, result unchanged.
        prev = result_tb;
        @(negedge ip_clk_tb);
        start_tb = 1'b1;
        funct_tb = 3'd5;
        a_tb     = 32'd1000;
        b_tb     = 32'd7;
        @(posedge ip_clk_tb);
        #1;
        start_tb = 1'b0;
        repeat (5) @(posedge ip_clk_tb);
        #1;
        kill_tb = 1'b1;
        @(posedge ip_clk_tb);
        #1;
        kill_tb = 1'b0;
        check("kill busy drop", {31'b0, busy_tb}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_tb) saw_done = 1'b1;
            @(posedge ip_clk_tb);
            #1;
        end
        check("kill no done", {31'b0, saw_done}, 32'd0);
        check("kill result kept", result_tb, prev);

        // Kill together with start in IDLE suppresses the start.
        @(negedge ip_clk_tb);
        start_tb = 1'b1;
        kill_tb  = 1'b1;
        funct_tb = 3'd0;
        a_tb     = 32'd3;
        b_tb     = 32'd3;
        @(posedge ip_clk_tb);
        #1;
        start_tb = 1'b0;
        kill_tb  = 1'b0;
        check("idle kill busy", {31'b0, busy_tb}, 32'd0);
        check("idle kill done", {31'b0, done_tb}, 32'd0);

        // Reset mid-operation clears outputs without waiting for a clock edge.
        @(negedge ip_clk_tb);
        start_tb = 1'b1;
        funct_tb = 3'd0;
        a_tb     = 32'd123;
        b_tb     = 32'd456;
        @(posedge ip_clk_tb);
        #1;
        start_tb = 1'b0;
        k = 0;
        while (k < 12) begin
            @(posedge ip_clk_tb);
            #1;
            k++;
        end
        check("pre-reset busy", {31'b0, busy_tb}, 32'd1);
        #2;
        ip_rst_n_tb = 1'b0;
        #1;
        check("mid reset result", result_tb, 32'h0);
        check("mid reset busy", {31'b0, busy_tb}, 32'd0);
        check("mid reset done", {31'b0, done_tb}, 32'd0);
        repeat (2) @(posedge ip_clk_tb);
        @(negedge ip_clk_tb);
        ip_rst_n_tb = 1'b1;
        run_op(3'd0, 32'd6, 32'd7, -1, "post reset mul");

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
